// File: rtl/bs_pkg.sv
// Shared constants for the barrel-shifter operand path: default widths, loader state encoding, frame bit order.
// Latency: none (types/constants only).
// Backpressure: not applicable.
package bs_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int SEL_W_DEF   = 2;
    localparam int FRAME_W_DEF = SEL_W_DEF + DATA_W_DEF;

    // Serial frames go MSB first, select field ahead of the data word.
    localparam bit FRAME_MSB_FIRST = 1'b1;
    localparam bit FRAME_SEL_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } ld_state_t;

    // Number of serial bits collected per frame, including an optional trailing parity bit.
    function automatic int frame_len(input int sel_w, input int data_w, input bit with_parity);
        return sel_w + data_w + (with_parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/bs_frame_counter.sv
// Counts accepted serial bits and flags the increment that completes a frame of LIMIT bits.
// Latency: tc is combinational on inc; the count wraps to 0 on the same edge.
// Backpressure: none; the counter only moves when inc is high.
module bs_frame_counter #(
    parameter int LIMIT = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic tc
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign tc = inc && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bs_operand_loader.sv
// Serial-to-parallel loader for the barrel shifter; optional trailing even parity under BS_LOADER_PARITY_EN.
// Latency: out_valid/s_out/w_out update on the edge that takes the last frame bit.
// Backpressure: out_ready handshake; bits arriving while a frame is held are dropped and flag overrun.
module bs_operand_loader
    import bs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic [DATA_W-1:0] w_out,
    output logic [SEL_W-1:0]  s_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
`ifdef BS_LOADER_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int FRAME_W = SEL_W + DATA_W;
`ifdef BS_LOADER_PARITY_EN
    localparam int COLLECT_W = frame_len(SEL_W, DATA_W, 1'b1);
`else
    localparam int COLLECT_W = frame_len(SEL_W, DATA_W, 1'b0);
`endif

    if (SEL_W != $clog2(DATA_W)) begin : g_bad_sel_w
        $error("SEL_W must equal clog2(DATA_W)");
    end

    ld_state_t            state;
    logic [COLLECT_W-1:0] sr;
    logic [COLLECT_W-1:0] sr_next;
    logic                 handshake;
    logic                 accept;
    logic                 frame_done;
    logic                 frame_ok;

    assign handshake = out_valid && out_ready;
    // A held frame blocks new bits unless it is being consumed this very cycle.
    assign accept    = ser_valid && ((state != HOLD) || handshake);
    assign sr_next   = COLLECT_W'({sr, ser_in});

`ifdef BS_LOADER_PARITY_EN
    assign frame_ok = ~(^sr_next);
`else
    assign frame_ok = 1'b1;
`endif

    bs_frame_counter #(
        .LIMIT (COLLECT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .tc  (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            w_out     <= '0;
            s_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef BS_LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (accept) begin
                sr <= sr_next;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                end
                HOLD: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (ser_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Completion overrides the per-state moves above.
            if (frame_done) begin
                busy <= 1'b0;
                if (frame_ok) begin
                    {s_out, w_out} <= sr_next[COLLECT_W-1 -: FRAME_W];
                    out_valid      <= 1'b1;
                    state          <= HOLD;
                end else begin
`ifdef BS_LOADER_PARITY_EN
                    parity_err <= 1'b1;
`endif
                    state      <= IDLE;
                end
            end
        end
    end

endmodule
